// File: rtl/addsub_pipe.sv
// Pipelined two's-complement adder/subtractor. The carry chain is cut into STAGES chunks of
// WIDTH/STAGES bits; operands are skewed in and sums deskewed out so one op issues per cycle.
module addsub_pipe #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int unsigned CW = WIDTH / STAGES;

  if (STAGES < 1 || WIDTH % STAGES != 0) begin : g_param_check
    $error("addsub_pipe: STAGES must be >= 1 and divide WIDTH evenly");
  end

  // Single global advance: the whole pipe moves or holds as one, bubbles included.
  logic adv;
  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    localparam int unsigned RW = WIDTH - g * CW;  // operand bits not yet consumed
    localparam int unsigned SW = (g + 1) * CW;    // sum bits resolved after this stage

    logic [RW-1:0] a_in;
    logic [RW-1:0] b_in;
    logic          c_in;
    logic          v_in;
    logic          v_q;
    logic [CW:0]   chunk;
    logic [SW-1:0] s_new;

    if (g == 0) begin : g_head
      // Subtraction is a + ~b + ~cin, so cin acts as a borrow.
      assign a_in  = a;
      assign b_in  = b ^ {WIDTH{sub}};
      assign c_in  = cin ^ sub;
      assign v_in  = in_valid;
      assign s_new = chunk[CW-1:0];
    end else begin : g_tail
      assign a_in  = g_stage[g-1].g_fwd.a_q;
      assign b_in  = g_stage[g-1].g_fwd.b_q;
      assign c_in  = g_stage[g-1].g_fwd.c_q;
      assign v_in  = g_stage[g-1].v_q;
      assign s_new = {chunk[CW-1:0], g_stage[g-1].g_fwd.s_q};
    end

    assign chunk = {1'b0, a_in[CW-1:0]} + {1'b0, b_in[CW-1:0]} + {{CW{1'b0}}, c_in};

    always_ff @(posedge clk) begin
      if (rst) begin
        v_q <= 1'b0;
      end else if (adv) begin
        v_q <= v_in;
      end
    end

    if (g < STAGES - 1) begin : g_fwd
      logic [RW-CW-1:0] a_q;
      logic [RW-CW-1:0] b_q;
      logic [SW-1:0]    s_q;
      logic             c_q;

      // Data registers load only with a valid slot; bubbles leave them untouched.
      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
          s_q <= '0;
          c_q <= 1'b0;
        end else if (adv && v_in) begin
          a_q <= a_in[RW-1:CW];
          b_q <= b_in[RW-1:CW];
          s_q <= s_new;
          c_q <= chunk[CW];
        end
      end
    end else begin : g_last
      logic [WIDTH-1:0] s_q;
      logic             c_q;
      logic             ovf_q;
      logic             zero_q;
      logic             msb_cin;

      // Carry into the MSB recovered from the MSB sum bit and its operands.
      assign msb_cin = a_in[CW-1] ^ b_in[CW-1] ^ chunk[CW-1];

      always_ff @(posedge clk) begin
        if (rst) begin
          s_q    <= '0;
          c_q    <= 1'b0;
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
        end else if (adv && v_in) begin
          s_q    <= s_new;
          c_q    <= chunk[CW];
          ovf_q  <= msb_cin ^ chunk[CW];
          zero_q <= ~|s_new;
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].v_q;
  assign result    = g_stage[STAGES-1].g_last.s_q;
  assign cout      = g_stage[STAGES-1].g_last.c_q;
  assign ovf       = g_stage[STAGES-1].g_last.ovf_q;
  assign zero      = g_stage[STAGES-1].g_last.zero_q;
  assign neg       = result[WIDTH-1];

endmodule

// File: doc/addsub_pipe.md
Name: addsub_pipe

Overview:
- Parametrised, pipelined two's-complement adder/subtractor; successor to the team's 4-bit ripple add/sub.
- Operand width is generic and the carry chain is split into STAGES registered chunks, giving one operation per cycle at high clock rate.
- Valid/ready handshakes on both sides.
- Outputs status flags (carry, signed overflow, zero, negative); feeds the ALU datapath.

Parameters:
- WIDTH, 16, operand/result width in bits.
- STAGES, 4, pipeline depth = number of carry chunks. Must be ≥1 and WIDTH % STAGES == 0. Chunk width CW = WIDTH/STAGES.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operation presented
- in_ready  output  1  block accepts operation this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- sub  input  1  0 = A+B+cin; 1 = A−B−cin (cin acts as borrow)
- cin  input  1  carry-in (add) / borrow-in (sub)
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- result  output  WIDTH  sum/difference modulo 2^WIDTH
- cout  output  1  carry out; in sub mode 1 = no borrow
- ovf  output  1  signed overflow
- zero  output  1  result == 0
- neg  output  1  result[WIDTH-1]

Behaviour:
- Reset (rst=1 at clk edge):
  - All stage valid bits cleared.
  - out_valid=0; result, cout, ovf, zero, neg = 0.
  - in_ready=1 in the first cycle after reset.
  - Reset overrides any concurrent handshake; in-flight operations are discarded and never emerged.
- Operand conditioning at input:
  - b_eff = b XOR {WIDTH{sub}}.
  - c0 = cin XOR sub. Sub therefore computes a + ~b + ~cin.
- Pipeline:
  - Stage k (0..STAGES−1) adds chunk k of a and b_eff plus the carry registered from stage k−1 (c0 for stage 0).
  - Operand chunks above k are carried forward unmodified (input skew).
  - Sum chunks below k are carried forward (output deskew).
  - Final stage registers the full result and flags.
- Latency: exactly STAGES cycles from accepting handshake (in_valid & in_ready) to out_valid, absent backpressure. Throughput is 1 op/cycle.
- Flags, computed from the final chunk:
  - cout = carry out of MSB.
  - ovf = carry into MSB XOR carry out of MSB.
  - zero = ~|result.
  - neg = result[WIDTH−1].
- Flow control:
  - Global advance enable adv = out_ready | ~out_valid.
  - in_ready = adv, combinational from out_ready and out_valid only; never depends on in_valid.
  - When adv=0 all stages, including valid bits, hold their values.
  - Pipeline bubbles propagate as valid=0 slots; empty slots are not collapsed while stalled.
- Output stability: while out_valid=1 and out_ready=0, result and flags are held stable.
- Ordering: results emerge in acceptance order; none are dropped or duplicated.
- STAGES=1: single registered ripple adder, latency 1.
- STAGES=WIDTH: one bit per stage (CW=1); must be legal.
- Simultaneous accept and emit in the same cycle is allowed and supports full throughput.
- No combinational path from a/b/sub/cin to any output.

Test Plan (defaults WIDTH=16, STAGES=4 unless stated):
1. Full carry chain: a=0xFFFF, b=0x0001, sub=0, cin=0 → after 4 cycles result=0x0000, cout=1, zero=1, ovf=0, neg=0.
2. Signed overflow:
   - a=0x7FFF, b=0x0001, add → result=0x8000, ovf=1, neg=1, cout=0.
   - a=0x8000, b=0x0001, sub → result=0x7FFF, ovf=1, cout=1.
3. Subtract/borrow:
   - 0x1234−0x1234, cin=0 → result=0x0000, zero=1, cout=1.
   - 0x0000−0x0001 → result=0xFFFF, cout=0, neg=1.
   - 0x0005−0x0002, cin=1 → result=0x0002.
4. Backpressure: issue 8 back-to-back random ops, out_ready held low cycles 5–7 → in_ready low in exactly those stall cycles; result/flags stable while stalled; all 8 results match the reference model, in order, none lost.
5. Reset mid-stream: 3 ops in flight, assert rst one cycle → next cycle out_valid=0 and outputs zero; the 3 ops never appear; a new op issued after reset emerges 4 cycles later, correct.
6. Parameter sweep: WIDTH=8 with STAGES∈{1,2,8}, exhaustive a,b,sub,cin (2^18 vectors) against the reference model → zero mismatches; latency equals STAGES in each configuration.
